// File: rtl/acc_vec_packer.sv
// acc_vec_packer: packs a serial stream of signed 8-bit samples into
// four-lane vectors X1..X4 and offers each one with a valid/ready handshake.
// A short frame (in_last before lane 3) is padded with PAD_VAL.
// Optional build macro ACC_PACK_DBUF_EN adds a second fill buffer so
// samples keep flowing while a vector waits for the consumer.
module acc_vec_packer #(
  parameter logic signed [7:0] PAD_VAL = 8'sd0,
  parameter int                CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic signed [7:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic signed [7:0]       X1,
  output logic signed [7:0]       X2,
  output logic signed [7:0]       X3,
  output logic signed [7:0]       X4,
  output logic                    vec_valid,
  input  logic                    vec_ready,
  output logic [CNT_W-1:0]        vec_count
);

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef logic [3:0][7:0] lanes_t;

  // Write one sample into lane pos; on last, pad every lane above pos.
  function automatic lanes_t write_lane(input lanes_t cur, input logic [1:0] pos,
                                        input logic [7:0] data, input logic last);
    lanes_t res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == pos) begin
        res[i] = data;
      end else if (last && (2'(i) > pos)) begin
        res[i] = PAD_VAL;
      end else begin
        res[i] = cur[i];
      end
    end
    return res;
  endfunction

  state_t           state_r, state_nxt_s;
  lanes_t           lane_r, lane_nxt_s;
  logic [1:0]       idx_r, idx_nxt_s;
  logic             vv_r, vv_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             live_r;
  logic             accept_s;
  logic             hshake_s;

`ifdef ACC_PACK_DBUF_EN
  lanes_t           b_r, b_nxt_s;
  logic [1:0]       b_idx_r, b_idx_nxt_s;
  logic             b_full_r, b_full_nxt_s;
`endif

  assign accept_s = in_valid & in_ready;
  assign hshake_s = vv_r & vec_ready;

  // in_ready is decoded from registered state only, never from vec_ready.
`ifdef ACC_PACK_DBUF_EN
  assign in_ready = live_r & ~((state_r == SEND) & b_full_r);
`else
  assign in_ready = live_r & (state_r == FILL);
`endif

  assign X1        = $signed(lane_r[0]);
  assign X2        = $signed(lane_r[1]);
  assign X3        = $signed(lane_r[2]);
  assign X4        = $signed(lane_r[3]);
  assign vec_valid = vv_r;
  assign vec_count = count_r;

  // Next-state, lane and counter decode for the FILL/SEND machine.
  always_comb begin
    state_nxt_s = state_r;
    lane_nxt_s  = lane_r;
    idx_nxt_s   = idx_r;
    vv_nxt_s    = vv_r;
    count_nxt_s = count_r;
`ifdef ACC_PACK_DBUF_EN
    b_nxt_s      = b_r;
    b_idx_nxt_s  = b_idx_r;
    b_full_nxt_s = b_full_r;
`endif
    case (state_r)
      FILL: begin
        vv_nxt_s = 1'b0;
        if (accept_s) begin
          lane_nxt_s = write_lane(lane_r, idx_r, in_data, in_last);
          if (in_last || (idx_r == 2'd3)) begin
            state_nxt_s = SEND;
            vv_nxt_s    = 1'b1;
            idx_nxt_s   = 2'd0;
          end else begin
            idx_nxt_s = idx_r + 2'd1;
          end
        end else begin
          lane_nxt_s = lane_r;
        end
      end
      SEND: begin
`ifdef ACC_PACK_DBUF_EN
        // Samples arriving while A waits are gathered in buffer B.
        if (accept_s) begin
          b_nxt_s = write_lane(b_r, b_idx_r, in_data, in_last);
          if (in_last || (b_idx_r == 2'd3)) begin
            b_full_nxt_s = 1'b1;
            b_idx_nxt_s  = 2'd0;
          end else begin
            b_idx_nxt_s = b_idx_r + 2'd1;
          end
        end else begin
          b_nxt_s = b_r;
        end
        if (hshake_s) begin
          count_nxt_s = count_r + CNT_W'(1);
          lane_nxt_s  = b_nxt_s;
          if (b_full_nxt_s) begin
            // B (complete now or already) becomes the next vector: no bubble.
            state_nxt_s  = SEND;
            vv_nxt_s     = 1'b1;
            idx_nxt_s    = 2'd0;
            b_full_nxt_s = 1'b0;
            b_idx_nxt_s  = 2'd0;
          end else begin
            // Partial B continues filling in the main lanes.
            state_nxt_s = FILL;
            vv_nxt_s    = 1'b0;
            idx_nxt_s   = b_idx_nxt_s;
            b_idx_nxt_s = 2'd0;
          end
        end else begin
          lane_nxt_s = lane_r;
          vv_nxt_s   = 1'b1;
        end
`else
        if (hshake_s) begin
          count_nxt_s = count_r + CNT_W'(1);
          state_nxt_s = FILL;
          vv_nxt_s    = 1'b0;
          idx_nxt_s   = 2'd0;
        end else begin
          vv_nxt_s = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt_s = FILL;
        vv_nxt_s    = 1'b0;
        idx_nxt_s   = 2'd0;
      end
    endcase
  end

  // State, lanes, counter and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_r <= FILL;
      lane_r  <= '0;
      idx_r   <= 2'd0;
      vv_r    <= 1'b0;
      count_r <= '0;
      live_r  <= 1'b0;
`ifdef ACC_PACK_DBUF_EN
      b_r      <= '0;
      b_idx_r  <= 2'd0;
      b_full_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      lane_r  <= lane_nxt_s;
      idx_r   <= idx_nxt_s;
      vv_r    <= vv_nxt_s;
      count_r <= count_nxt_s;
      live_r  <= 1'b1;
`ifdef ACC_PACK_DBUF_EN
      b_r      <= b_nxt_s;
      b_idx_r  <= b_idx_nxt_s;
      b_full_r <= b_full_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_acc_vec_packer.sv
// Table-driven bench for acc_vec_packer. A second instance with CNT_W=3 and
// PAD_VAL=-1 shares the stimulus to exercise counter wrap and padding value.
module tb_acc_vec_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              arst = 1'b1;
  logic signed [7:0] in_data = 8'sd0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              vec_ready = 1'b0;

  logic              in_ready, vec_valid;
  logic signed [7:0] X1, X2, X3, X4;
  logic [15:0]       vec_count;
  logic              w_in_ready, w_vec_valid;
  logic signed [7:0] wX1, wX2, wX3, wX4;
  logic [2:0]        w_vec_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt   = 0;

`ifdef ACC_PACK_DBUF_EN
  localparam int DBUF = 1;
`else
  localparam int DBUF = 0;
`endif

  acc_vec_packer dut (
    .clk(clk), .arst(arst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .X1(X1), .X2(X2), .X3(X3), .X4(X4), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_count(vec_count)
  );

  acc_vec_packer #(.PAD_VAL(-8'sd1), .CNT_W(3)) dut_w (
    .clk(clk), .arst(arst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(w_in_ready), .X1(wX1), .X2(wX2), .X3(wX3), .X4(wX4), .vec_valid(w_vec_valid),
    .vec_ready(vec_ready), .vec_count(w_vec_count)
  );

  typedef struct packed {
    logic [3:0][7:0] s;
    logic [2:0]      n;
    logic            last;
    logic            gap;
    logic [3:0]      hold;
    logic [3:0][7:0] e;
    logic [3:0][7:0] w;
  } vec_t;

  function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                              input int n, input int last, input int gap, input int hold,
                              input int e0, input int e1, input int e2, input int e3,
                              input int w0, input int w1, input int w2, input int w3);
    vec_t v;
    v.s[0] = 8'(s0); v.s[1] = 8'(s1); v.s[2] = 8'(s2); v.s[3] = 8'(s3);
    v.e[0] = 8'(e0); v.e[1] = 8'(e1); v.e[2] = 8'(e2); v.e[3] = 8'(e3);
    v.w[0] = 8'(w0); v.w[1] = 8'(w1); v.w[2] = 8'(w2); v.w[3] = 8'(w3);
    v.n = 3'(n); v.last = 1'(last); v.gap = 1'(gap); v.hold = 4'(hold);
    return v;
  endfunction

  task automatic chk(input string name, input integer act, input integer exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input vec_t v);
    chk({tag, " X1"}, X1, $signed(v.e[0]));
    chk({tag, " X2"}, X2, $signed(v.e[1]));
    chk({tag, " X3"}, X3, $signed(v.e[2]));
    chk({tag, " X4"}, X4, $signed(v.e[3]));
    chk({tag, " wX1"}, wX1, $signed(v.w[0]));
    chk({tag, " wX2"}, wX2, $signed(v.w[1]));
    chk({tag, " wX3"}, wX3, $signed(v.w[2]));
    chk({tag, " wX4"}, wX4, $signed(v.w[3]));
  endtask

  task automatic chk_count(input string tag);
    chk({tag, " vec_count"}, vec_count, cnt % 65536);
    chk({tag, " w_vec_count"}, w_vec_count, cnt % 8);
  endtask

  task automatic feed(input int s, input bit last);
    @(negedge clk);
    chk("in_ready before sample", in_ready, 1);
    in_data = 8'(s); in_valid = 1'b1; in_last = last;
  endtask

  // Feed one vector, check it is presented, optionally held, then handshake it.
  task automatic run_vec(input string tag, input vec_t v);
    for (int k = 0; k < int'(v.n); k++) begin
      feed($signed(v.s[k]), (k == int'(v.n) - 1) && v.last);
      if (v.gap && (k < int'(v.n) - 1)) begin
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b1; in_data = 8'sh55;
        chk({tag, " valid during fill"}, vec_valid, 0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk({tag, " vec_valid"}, vec_valid, 1);
    chk({tag, " w_vec_valid"}, w_vec_valid, 1);
    chk({tag, " in_ready in SEND"}, in_ready, DBUF);
    chk_lanes(tag, v);
    chk_count(tag);
    for (int h = 0; h < int'(v.hold); h++) begin
      @(negedge clk);
      chk({tag, " hold vec_valid"}, vec_valid, 1);
      chk({tag, " hold in_ready"}, in_ready, DBUF);
      chk_lanes({tag, " hold"}, v);
      chk_count({tag, " hold"});
    end
    vec_ready = 1'b1;
    @(negedge clk);
    vec_ready = 1'b0;
    cnt++;
    chk({tag, " valid after hs"}, vec_valid, 0);
    chk_count({tag, " after hs"});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    arst = 1'b1; in_valid = 1'b0; in_last = 1'b0; vec_ready = 1'b0;
    @(negedge clk);
    cnt = 0;
    chk({tag, " vec_valid"}, vec_valid, 0);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " X1"}, X1, 0);
    chk({tag, " X2"}, X2, 0);
    chk({tag, " X3"}, X3, 0);
    chk({tag, " X4"}, X4, 0);
    chk_count(tag);
    arst = 1'b0;
    @(negedge clk);
    chk({tag, " in_ready after"}, in_ready, 1);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = mk(1, 2, 3, 4,        4, 0, 0, 0,  1, 2, 3, 4,        1, 2, 3, 4);
    tbl[1] = mk(-128, 127, -1, 0,  4, 0, 0, 10, -128, 127, -1, 0,  -128, 127, -1, 0);
    tbl[2] = mk(5, 6, 0, 0,        2, 1, 0, 0,  5, 6, 0, 0,        5, 6, -1, -1);
    tbl[3] = mk(9, 0, 0, 0,        1, 1, 0, 0,  9, 0, 0, 0,        9, -1, -1, -1);
    tbl[4] = mk(10, 20, 30, 40,    4, 1, 0, 0,  10, 20, 30, 40,    10, 20, 30, 40);
    tbl[5] = mk(-5, -6, -7, 0,     3, 1, 0, 2,  -5, -6, -7, 0,     -5, -6, -7, -1);
    tbl[6] = mk(11, 12, 13, 14,    4, 0, 1, 0,  11, 12, 13, 14,    11, 12, 13, 14);

    do_reset("reset");

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("tbl%0d", i), tbl[i]);
    end

    // Reset with three lanes filled discards the partial vector.
    feed(7, 1'b0); feed(8, 1'b0); feed(9, 1'b0);
    do_reset("rst_fill");
    run_vec("after rst_fill", mk(21, 22, 23, 24, 4, 0, 0, 0, 21, 22, 23, 24, 21, 22, 23, 24));

    // Reset while a vector is pending drops it without a handshake.
    feed(31, 1'b0); feed(32, 1'b0); feed(33, 1'b0); feed(34, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pending before rst", vec_valid, 1);
    do_reset("rst_send");
    run_vec("after rst_send", mk(41, 0, 0, 0, 1, 1, 0, 0, 41, 0, 0, 0, 41, -1, -1, -1));

    // Counter run: the 3-bit instance wraps 7 -> 0.
    for (int j = 0; j < 9; j++) begin
      run_vec($sformatf("wrap%0d", j),
              mk(j, j + 1, -j, 100, 4, 0, 0, 0, j, j + 1, -j, 100, j, j + 1, -j, 100));
    end

`ifdef ACC_PACK_DBUF_EN
    begin
      int nv;
      vec_t va, vb;
      va = mk(60, 61, 62, 63, 4, 0, 0, 0, 60, 61, 62, 63, 60, 61, 62, 63);
      vb = mk(64, 65, 66, 67, 4, 0, 0, 0, 64, 65, 66, 67, 64, 65, 66, 67);
      // Continuous stream with the consumer always ready.
      nv = 0;
      vec_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (vec_valid) begin
          chk_lanes($sformatf("stream v%0d", nv), (nv == 0) ? va : vb);
          nv++;
          cnt++;
        end
        if (c < 8) begin
          chk("stream in_ready", in_ready, 1);
          in_data = 8'(60 + c); in_valid = 1'b1; in_last = 1'b0;
        end else begin
          in_valid = 1'b0;
        end
      end
      vec_ready = 1'b0;
      chk("stream vectors", nv, 2);
      chk_count("stream");

      // A pending while B fills; B full stalls input; back-to-back release.
      for (int c = 0; c < 8; c++) feed(64 + c - 4, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("dbuf stall in_ready", in_ready, 0);
      chk_lanes("dbuf A", mk(0, 0, 0, 0, 4, 0, 0, 0, 60, 61, 62, 63, 60, 61, 62, 63));
      vec_ready = 1'b1;
      @(negedge clk);
      cnt++;
      chk("dbuf B valid", vec_valid, 1);
      chk_lanes("dbuf B", vb);
      @(negedge clk);
      cnt++;
      vec_ready = 1'b0;
      chk("dbuf B done", vec_valid, 0);
      chk_count("dbuf");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
